vdp18_vram_addr_seq: RTL

- Registered, parametrised VRAM address sequencer for the vdp18 core.
- Forms the VRAM address for each access slot and owns the CPU address pointer, including load and auto-increment.
- Drives a req/ack handshake to the VRAM controller.
- Widens addressing beyond 16K through ADDR_W and a page-extension register.

---
 rtl/vdp18_vram_addr_seq_if.sv | 24 ++
 rtl/vdp18_vram_addr_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/vdp18_vram_addr_seq_if.sv
// VRAM request/ack bus between the address sequencer and the VRAM controller.
// The sequencer holds vram_a_o/vram_cpu_o stable while vram_req_o is high.
interface vdp18_vram_addr_seq_if #(
    parameter int ADDR_W = 14
);
    logic [ADDR_W-1:0] vram_a_o;
    logic              vram_req_o;
    logic              vram_cpu_o;
    logic              vram_ack_i;

    modport master (
        output vram_a_o,
        output vram_req_o,
        output vram_cpu_o,
        input  vram_ack_i
    );

    modport slave (
        input  vram_a_o,
        input  vram_req_o,
        input  vram_cpu_o,
        output vram_ack_i
    );
endinterface

// File: rtl/vdp18_vram_addr_seq.sv
// vdp18 VRAM address sequencer: slot address mux, CPU pointer, req/ack FSM.
// Optional overrun counter is enabled with `define VDP18_OVERRUN_CNT_EN.
package vdp18_pkg;
    typedef enum logic [3:0] {
        AC_NONE, AC_PNT, AC_PCT, AC_PGT,
        AC_STST, AC_SATY, AC_SATX, AC_SATN,
        AC_SATC, AC_SPTH, AC_SPTL, AC_CPU
    } access_t;

    typedef enum logic [1:0] {
        OPMODE_GRAPH1, OPMODE_GRAPH2,
        OPMODE_MULTIC, OPMODE_TEXTM
    } opmode_t;
endpackage

module vdp18_vram_addr_seq
    import vdp18_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter bit INC_ON_ACK = 1'b1
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              clk_en_i,
    input  access_t           access_type_i,
    input  opmode_t           opmode_i,
    input  logic [8:0]        num_line_i,
    input  logic [3:0]        reg_ntb_i,
    input  logic [7:0]        reg_ctb_i,
    input  logic [2:0]        reg_pgb_i,
    input  logic [6:0]        reg_satb_i,
    input  logic [2:0]        reg_spgb_i,
    input  logic              reg_size1_i,
    input  logic [1:0]        reg_page_i,
    input  logic [9:0]        pat_table_i,
    input  logic [7:0]        pat_name_i,
    input  logic [4:0]        spr_num_i,
    input  logic [3:0]        spr_line_i,
    input  logic [7:0]        spr_name_i,
    input  logic              cpu_ld_lo_i,
    input  logic              cpu_ld_hi_i,
    input  logic [7:0]        cpu_data_i,
    input  logic              cpu_inc_i,
    vdp18_vram_addr_seq_if.master vram,
    output logic [ADDR_W-1:0] cpu_addr_o,
    output logic              ovr_o,
    output logic [7:0]        ovr_cnt_o
);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic              req_q, req_d;
    logic              cpu_q, cpu_d;
    logic              ovr_q, ovr_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [13:0]       lo_a;
    logic [ADDR_W-1:0] slot_a;
    logic              slot;
    logic              drop;
    logic              inc_ev;
    logic              is_cpu;

    assign slot   = clk_en_i && (access_type_i != AC_NONE);
    assign is_cpu = (access_type_i == AC_CPU);

    // Low 14 address bits; vdp18 MSB-first indices mapped to [msb:lsb].
    always_comb begin
        lo_a = '0;
        unique case (access_type_i)
            AC_CPU: lo_a = ptr_q[13:0];
            AC_PNT: lo_a = {reg_ntb_i, pat_table_i};
            AC_PCT: begin
                unique case (opmode_i)
                    OPMODE_GRAPH1:
                        lo_a = {reg_ctb_i, 1'b0, pat_name_i[7:3]};
                    OPMODE_GRAPH2:
                        lo_a = {reg_ctb_i[7],
                                num_line_i[7:6] & reg_ctb_i[6:5],
                                pat_name_i & {reg_ctb_i[4:0], 3'b111},
                                num_line_i[2:0]};
                    default: lo_a = '0;
                endcase
            end
            AC_PGT: begin
                unique case (opmode_i)
                    OPMODE_TEXTM, OPMODE_GRAPH1:
                        lo_a = {reg_pgb_i, pat_name_i, num_line_i[2:0]};
                    OPMODE_MULTIC:
                        lo_a = {reg_pgb_i, pat_name_i, num_line_i[4:2]};
                    OPMODE_GRAPH2:
                        lo_a = {reg_pgb_i[2],
                                num_line_i[7:6] & reg_pgb_i[1:0],
                                pat_name_i & {reg_ctb_i[4:0], 3'b111},
                                num_line_i[2:0]};
                    default: lo_a = '0;
                endcase
            end
            AC_STST, AC_SATY: lo_a = {reg_satb_i, spr_num_i, 2'b00};
            AC_SATX:          lo_a = {reg_satb_i, spr_num_i, 2'b01};
            AC_SATN:          lo_a = {reg_satb_i, spr_num_i, 2'b10};
            AC_SATC:          lo_a = {reg_satb_i, spr_num_i, 2'b11};
            AC_SPTH: begin
                if (reg_size1_i)
                    lo_a = {reg_spgb_i, spr_name_i[7:2], 1'b0, spr_line_i};
                else
                    lo_a = {reg_spgb_i, spr_name_i, spr_line_i[2:0]};
            end
            AC_SPTL: lo_a = {reg_spgb_i, spr_name_i[7:2], 1'b1, spr_line_i};
            default: lo_a = '0;
        endcase
    end

    generate
        if (ADDR_W == 16) begin : g_w16
            logic [1:0] hi_a;
            assign hi_a   = is_cpu ? ptr_q[15:14] : reg_page_i;
            assign slot_a = {hi_a, lo_a};
        end else begin : g_w14
            assign slot_a = lo_a;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        req_d   = req_q;
        cpu_d   = cpu_q;
        ovr_d   = ovr_q;
        drop    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (slot) begin
                    a_d     = slot_a;
                    req_d   = 1'b1;
                    cpu_d   = is_cpu;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (vram.vram_ack_i) begin
                    if (slot) begin
                        a_d   = slot_a;
                        cpu_d = is_cpu;
                    end else begin
                        req_d   = 1'b0;
                        cpu_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end else if (slot) begin
                    // Controller still busy: keep the old request, lose the new slot.
                    drop  = 1'b1;
                    ovr_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign inc_ev = INC_ON_ACK ? (vram.vram_ack_i && req_q && cpu_q)
                               : cpu_inc_i;

    always_comb begin
        ptr_d = ptr_q;
        if (cpu_ld_lo_i || cpu_ld_hi_i) begin
            if (cpu_ld_lo_i) ptr_d[7:0] = cpu_data_i;
            if (cpu_ld_hi_i) ptr_d[ADDR_W-1:8] = cpu_data_i[ADDR_W-9:0];
        end else if (inc_ev) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            req_q   <= 1'b0;
            cpu_q   <= 1'b0;
            ovr_q   <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            req_q   <= req_d;
            cpu_q   <= cpu_d;
            ovr_q   <= ovr_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef VDP18_OVERRUN_CNT_EN
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (drop && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end

    assign ovr_cnt_o = cnt_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
    assign ovr_cnt_o   = 8'h00;
`endif

    logic unused_in;
    assign unused_in = ^{num_line_i[8], num_line_i[5], cpu_inc_i,
                         cpu_data_i, reg_page_i};

    assign vram.vram_a_o   = a_q;
    assign vram.vram_req_o = req_q;
    assign vram.vram_cpu_o = cpu_q;
    assign cpu_addr_o      = ptr_q;
    assign ovr_o           = ovr_q;

endmodule
